stc0_egress_framer: RTL and testbench



---
 rtl/stc0_pkg.sv | 16 +
 rtl/stc0_sync_fifo.sv | 61 ++++++
 rtl/stc0_egress_framer.sv | 86 ++++++++
 tb/tb_stc0_egress_framer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/stc0_pkg.sv
// Shared stc0 constants: sample geometry and FFT frame size, so the framer and
// the biplex FFT front end agree on how many pairs make one frame.
package stc0_pkg;

   localparam int STC0_DATA_WIDTH       = 16;
   localparam int STC0_DEPTH_LOG2       = 3;
   localparam int STC0_FRAME_PAIRS_LOG2 = 4;

   // One stored word holds an A sample and a B sample, each {re, im}.
   localparam int STC0_PAIR_W = 4 * STC0_DATA_WIDTH;

   function automatic int stc0_pair_w(input int data_width);
      return 4 * data_width;
   endfunction

endpackage

// File: rtl/stc0_sync_fifo.sv
// Generic single-clock FIFO built from pointers plus an occupancy count;
// head data is read combinationally and a push while full may ride on a pop.
module stc0_sync_fifo #(
   parameter int WIDTH      = 64,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wr_data,
   output logic [WIDTH-1:0]      rd_data,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  empty,
   output logic                  drop
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [WIDTH-1:0]      mem_reg [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg;
   logic [DEPTH_LOG2-1:0] rd_ptr_reg;
   logic [DEPTH_LOG2:0]   count_reg;
   logic                  pop_ok;
   logic                  push_ok;

   assign full    = (count_reg == LVL_FULL);
   assign empty   = (count_reg == '0);
   assign pop_ok  = pop & ~empty;
   // Flush and reset win over a same-cycle push; such a push is neither stored nor a drop.
   assign push_ok = push & (~full | pop_ok) & ~flush & rst_n;
   assign drop    = push & full & ~pop_ok & ~flush & rst_n;
   assign level   = count_reg;
   assign rd_data = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + LVL_ONE;
            2'b01:   count_reg <= count_reg - LVL_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_reg[wr_ptr_reg] <= wr_data;
   end

endmodule

// File: rtl/stc0_egress_framer.sv
// Buffers A/B egress pairs for the biplex FFT front end, tags frame boundaries
// from a pop counter and flags pairs lost because the producer cannot stall.
module stc0_egress_framer
   import stc0_pkg::*;
#(
   parameter int DATA_WIDTH       = STC0_DATA_WIDTH,
   parameter int DEPTH_LOG2       = STC0_DEPTH_LOG2,
   parameter int FRAME_PAIRS_LOG2 = STC0_FRAME_PAIRS_LOG2
) (
   input  logic                    Clk,
   input  logic                    RstN,
   input  logic [2*DATA_WIDTH-1:0] AIngress,
   input  logic [2*DATA_WIDTH-1:0] BIngress,
   input  logic                    IngressValid,
   input  logic                    Flush,
   output logic [2*DATA_WIDTH-1:0] AOut,
   output logic [2*DATA_WIDTH-1:0] BOut,
   output logic                    OutValid,
   input  logic                    OutReady,
   output logic                    OutSof,
   output logic                    OutEof,
   output logic [DEPTH_LOG2:0]     Level,
   output logic                    Overflow
);

   localparam int SW = 2 * DATA_WIDTH;
   localparam int PW = stc0_pair_w(DATA_WIDTH);

   logic [PW-1:0] head_pair;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_drop;
   logic          pop_fire;
   logic          overflow_reg;

   stc0_sync_fifo #(
      .WIDTH      (PW),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk     (Clk),
      .rst_n   (RstN),
      .flush   (Flush),
      .push    (IngressValid),
      .pop     (OutReady),
      .wr_data ({AIngress, BIngress}),
      .rd_data (head_pair),
      .level   (Level),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .drop    (fifo_drop)
   );

   assign AOut     = head_pair[PW-1 -: SW];
   assign BOut     = head_pair[SW-1:0];
   assign OutValid = ~fifo_empty;
   assign pop_fire = OutValid & OutReady;
   assign Overflow = overflow_reg;

   always_ff @(posedge Clk) begin
      if (!RstN || Flush) overflow_reg <= 1'b0;
      else if (fifo_drop) overflow_reg <= 1'b1;
   end

   generate
      if (FRAME_PAIRS_LOG2 > 0) begin : g_frame
         localparam logic [FRAME_PAIRS_LOG2-1:0] FRAME_ONE = FRAME_PAIRS_LOG2'(1);
         logic [FRAME_PAIRS_LOG2-1:0] frame_cnt_reg;

         always_ff @(posedge Clk) begin
            if (!RstN || Flush) frame_cnt_reg <= '0;
            else if (pop_fire)  frame_cnt_reg <= frame_cnt_reg + FRAME_ONE;
         end

         assign OutSof = (frame_cnt_reg == '0);
         assign OutEof = &frame_cnt_reg;
      end else begin : g_single
         // A one-pair frame: every pair both starts and ends its frame.
         assign OutSof = 1'b1;
         assign OutEof = 1'b1;
      end
   endgenerate

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_stc0_egress_framer.sv
// Table-driven bench: each row drives one cycle of inputs and states the
// expected pre-edge outputs for a 16-pair-frame DUT and a 4-pair-frame DUT.
module tb_stc0_egress_framer;

   logic        Clk = 1'b0;
   logic        RstN;
   logic [31:0] AIngress, BIngress;
   logic        IngressValid, Flush, OutReady;
   logic [31:0] AOut, BOut, AOutF, BOutF;
   logic        OutValid, OutSof, OutEof, Overflow;
   logic        OutValidF, OutSofF, OutEofF, OverflowF;
   logic [3:0]  Level, LevelF;

   always #5 Clk = ~Clk;

   stc0_egress_framer #(.DATA_WIDTH(16), .DEPTH_LOG2(3), .FRAME_PAIRS_LOG2(4)) dut (
      .Clk(Clk), .RstN(RstN), .AIngress(AIngress), .BIngress(BIngress),
      .IngressValid(IngressValid), .Flush(Flush), .AOut(AOut), .BOut(BOut),
      .OutValid(OutValid), .OutReady(OutReady), .OutSof(OutSof), .OutEof(OutEof),
      .Level(Level), .Overflow(Overflow));

   stc0_egress_framer #(.DATA_WIDTH(16), .DEPTH_LOG2(3), .FRAME_PAIRS_LOG2(2)) dut_f (
      .Clk(Clk), .RstN(RstN), .AIngress(AIngress), .BIngress(BIngress),
      .IngressValid(IngressValid), .Flush(Flush), .AOut(AOutF), .BOut(BOutF),
      .OutValid(OutValidF), .OutReady(OutReady), .OutSof(OutSofF), .OutEof(OutEofF),
      .Level(LevelF), .Overflow(OverflowF));

   // lvl/ovf/head/fc describe the state before this row's clock edge;
   // fc is the number of pops since the last reset or flush, head = -1 skips data.
   typedef struct {
      bit rstn; bit flush; bit iv; int din; bit ready;
      bit chk;  int lvl;   bit ovf; int head; int fc;
   } vec_t;

   vec_t vq[$];
   int checks = 0;
   int failures = 0;
   int row = 0;

   function automatic logic [31:0] pa(input int k);
      return {16'(4*k+1), 16'(4*k+2)};
   endfunction

   function automatic logic [31:0] pb(input int k);
      return {16'(4*k+3), 16'(4*k+4)};
   endfunction

   function automatic void add(input bit rstn, input bit flush, input bit iv, input int din,
                               input bit ready, input bit chk, input int lvl, input bit ovf,
                               input int head, input int fc);
      vec_t v;
      v.rstn = rstn; v.flush = flush; v.iv = iv; v.din = din; v.ready = ready;
      v.chk = chk; v.lvl = lvl; v.ovf = ovf; v.head = head; v.fc = fc;
      vq.push_back(v);
   endfunction

   task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%0h required=%0h", nm, row, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      RstN = v.rstn; Flush = v.flush; IngressValid = v.iv; OutReady = v.ready;
      AIngress = pa(v.din); BIngress = pb(v.din);
      #2;
      if (v.chk) begin
         ck("valid",  64'(OutValid),  64'(v.lvl != 0));
         ck("level",  64'(Level),     64'(v.lvl));
         ck("ovf",    64'(Overflow),  64'(v.ovf));
         ck("sof16",  64'(OutSof),    64'(v.fc % 16 == 0));
         ck("eof16",  64'(OutEof),    64'(v.fc % 16 == 15));
         ck("valid4", 64'(OutValidF), 64'(v.lvl != 0));
         ck("level4", 64'(LevelF),    64'(v.lvl));
         ck("ovf4",   64'(OverflowF), 64'(v.ovf));
         ck("sof4",   64'(OutSofF),   64'(v.fc % 4 == 0));
         ck("eof4",   64'(OutEofF),   64'(v.fc % 4 == 3));
         if (v.head >= 0) begin
            ck("head",  {AOut, BOut},   {pa(v.head), pb(v.head)});
            ck("head4", {AOutF, BOutF}, {pa(v.head), pb(v.head)});
         end
      end
      $display("row %0d rstn=%0d flush=%0d iv=%0d ready=%0d level=%0d valid=%0d ovf=%0d sof=%0d/%0d eof=%0d/%0d",
               row, v.rstn, v.flush, v.iv, v.ready, Level, OutValid, Overflow,
               OutSof, OutSofF, OutEof, OutEofF);
      @(posedge Clk);
      #1;
      row++;
   endtask

   initial begin
      RstN = 1'b0; Flush = 1'b0; IngressValid = 1'b0; OutReady = 1'b0;
      AIngress = '0; BIngress = '0;

      // reset held two cycles, then idle reset state
      add(0,0,0,0,0, 0, 0,0,-1,0);
      add(0,0,0,0,0, 0, 0,0,-1,0);
      add(1,0,0,0,0, 1, 0,0,-1,0);
      // fill 4 with OutReady=0, then drain in order
      for (int i = 0; i < 4; i++) add(1,0,1,i,0, 1, i,0, (i == 0) ? -1 : 0, 0);
      add(1,0,0,0,0, 1, 4,0,0,0);
      for (int i = 0; i < 4; i++) add(1,0,0,0,1, 1, 4-i,0,i,i);
      add(1,0,0,0,1, 1, 0,0,-1,4);
      add(1,0,0,0,0, 1, 0,0,-1,4);
      // overflow: 9 pushes, 9th dropped, drain shows pairs 4..11 only
      for (int i = 0; i < 9; i++) add(1,0,1,4+i,0, 1, i,0, (i == 0) ? -1 : 4, 4);
      add(1,0,0,0,0, 1, 8,1,4,4);
      for (int i = 0; i < 8; i++) add(1,0,0,0,1, 1, 8-i,1,4+i,4+i);
      add(1,0,0,0,0, 1, 0,1,-1,12);
      // flush with push clears overflow; then push+pop at full keeps level 8
      add(1,1,1,99,0, 1, 0,1,-1,12);
      add(1,0,0,0,0, 1, 0,0,-1,0);
      for (int i = 0; i < 8; i++) add(1,0,1,20+i,0, 1, i,0, (i == 0) ? -1 : 20, 0);
      add(1,0,1,28,1, 1, 8,0,20,0);
      add(1,0,0,0,0, 1, 8,0,21,1);
      for (int i = 0; i < 8; i++) add(1,0,0,0,1, 1, 8-i,0,21+i,1+i);
      add(1,0,0,0,0, 1, 0,0,-1,9);
      // frame tagging: stream 10 pairs with OutReady=1
      add(1,1,0,0,0, 1, 0,0,-1,9);
      for (int j = 0; j <= 10; j++)
         add(1,0, (j < 10), 40+j, 1, 1, (j == 0) ? 0 : 1, 0,
             (j == 0) ? -1 : 40+j-1, (j == 0) ? 0 : j-1);
      add(1,0,0,0,0, 1, 0,0,-1,10);
      // flush mid-frame after overflow, with 2 pairs stored and a push in flight
      add(1,1,0,0,0, 1, 0,0,-1,10);
      for (int i = 0; i < 9; i++) add(1,0,1,50+i,0, 1, i,0, (i == 0) ? -1 : 50, 0);
      for (int i = 0; i < 6; i++) add(1,0,0,0,1, 1, 8-i,1,50+i,i);
      add(1,1,1,60,0, 1, 2,1,56,6);
      add(1,0,0,0,0, 1, 0,0,-1,0);
      add(1,0,1,70,0, 1, 0,0,-1,0);
      add(1,0,0,0,1, 1, 1,0,70,0);
      // reset mid-stream while full with overflow set
      for (int i = 0; i < 9; i++) add(1,0,1,80+i,0, 1, i,0, (i == 0) ? -1 : 80, 1);
      add(1,0,0,0,0, 1, 8,1,80,1);
      add(0,0,1,90,1, 1, 8,1,80,1);
      add(1,0,0,0,0, 1, 0,0,-1,0);
      add(1,0,1,91,0, 1, 0,0,-1,0);
      add(1,0,0,0,0, 1, 1,0,91,0);

      foreach (vq[i]) apply(vq[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
